// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider.
// Each channel divides CLOCK by 2*HALF[ch]. It produces a 50% duty square wave
// and a one-cycle tick registered with every rising edge of that wave.
// All state changes on the falling edge of CLOCK.
module clk_div_multi #(
  parameter int unsigned NUM_CH   = 3,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned DEF_HALF = 25_000,
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync_clr,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic [NUM_CH-1:0] div_clk,
  output logic [NUM_CH-1:0] tick,
  output logic              cfg_err
);

  logic [NUM_CH-1:0][CNT_W-1:0] half_q, half_d;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0]            div_q, div_d;
  logic [NUM_CH-1:0]            tick_q, tick_d;
  logic [NUM_CH-1:0]            wr_sel;
  logic [NUM_CH-1:0]            wrap;
  logic                         cfg_ok;
  logic                         cfg_err_q, cfg_err_d;

  // Validate the config write and decode it to a one-hot channel select.
  always_comb begin
    cfg_ok    = cfg_we && (cfg_half != '0) && (32'(cfg_ch) < NUM_CH);
    cfg_err_d = cfg_we && !cfg_ok;
    wr_sel    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      wr_sel[i] = cfg_ok && (32'(cfg_ch) == i);
    end
  end

  // End of half period. The >= compare also forces a wrap if cnt ever
  // overshoots HALF-1, so the counter can never run away.
  always_comb begin
    wrap = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      wrap[i] = cnt_q[i] >= (half_q[i] - CNT_W'(1));
    end
  end

  // Per-channel next state: config write, then counting, then sync clear.
  always_comb begin
    half_d = half_q;
    cnt_d  = cnt_q;
    div_d  = div_q;
    tick_d = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (wr_sel[i]) begin
        // New period restarts from zero; the output level is kept.
        half_d[i] = cfg_half;
        cnt_d[i]  = '0;
      end else if (en[i]) begin
        if (wrap[i]) begin
          cnt_d[i]  = '0;
          div_d[i]  = ~div_q[i];
          tick_d[i] = ~div_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
      // Phase alignment wins over counting but leaves HALF alone, so a
      // simultaneous accepted write still lands.
      if (sync_clr) begin
        cnt_d[i]  = '0;
        div_d[i]  = 1'b0;
        tick_d[i] = 1'b0;
      end
    end
  end

  // State registers, async active-low reset, falling-edge clocked.
  always_ff @(negedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      half_q    <= {NUM_CH{CNT_W'(DEF_HALF)}};
      cnt_q     <= '0;
      div_q     <= '0;
      tick_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      half_q    <= half_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      tick_q    <= tick_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign div_clk = div_q;
  assign tick    = tick_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: directed scenarios plus an elapsed-time model.
module tb_clk_div_multi;

  localparam int unsigned NCH = 3;

  logic             CLOCK;
  logic             RESET_N;
  logic [NCH-1:0]   en;
  logic             sync_clr;
  logic             cfg_we;
  logic [1:0]       cfg_ch;
  logic [31:0]      cfg_half;
  logic [NCH-1:0]   div_clk;
  logic [NCH-1:0]   tick;
  logic             cfg_err;

  int  vectors     = 0;
  int  miscompares = 0;
  bit  chk_on      = 0;

  clk_div_multi #(
    .NUM_CH  (NCH),
    .CNT_W   (32),
    .DEF_HALF(5)
  ) dut (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .en      (en),
    .sync_clr(sync_clr),
    .cfg_we  (cfg_we),
    .cfg_ch  (cfg_ch),
    .cfg_half(cfg_half),
    .div_clk (div_clk),
    .tick    (tick),
    .cfg_err (cfg_err)
  );

  initial CLOCK = 1'b0;
  always #10 CLOCK = ~CLOCK;

  // Model: each channel is described by the number of enabled cycles since its
  // last phase anchor (reset, clear or write) and the level at that anchor.
  // The level is then anchor level XOR parity of completed half periods.
  int unsigned m_half [NCH] = '{5, 5, 5};
  int unsigned m_run  [NCH] = '{0, 0, 0};
  bit          m_lvl0 [NCH] = '{0, 0, 0};
  bit          m_step [NCH] = '{0, 0, 0};
  bit          m_err        = 0;

  function automatic bit m_clk(input int i);
    return m_lvl0[i] ^ (((m_run[i] / m_half[i]) % 2) == 1);
  endfunction

  function automatic bit m_tick(input int i);
    return m_step[i] && ((m_run[i] % m_half[i]) == 0) && m_clk(i);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model update at the same edges the design uses.
  always @(negedge CLOCK or negedge RESET_N) begin
    bit ok;
    bit cur;
    if (!RESET_N) begin
      for (int i = 0; i < NCH; i++) begin
        m_half[i] = 5; m_run[i] = 0; m_lvl0[i] = 0; m_step[i] = 0;
      end
      m_err = 0;
    end else begin
      ok    = cfg_we && (cfg_half != 0) && (int'(cfg_ch) < NCH);
      m_err = cfg_we && !ok;
      for (int i = 0; i < NCH; i++) begin
        cur       = m_clk(i);
        m_step[i] = 0;
        if (ok && int'(cfg_ch) == i) begin
          m_lvl0[i] = cur;
          m_run[i]  = 0;
          m_half[i] = cfg_half;
        end else if (en[i]) begin
          m_run[i]++;
          m_step[i] = 1;
        end
        if (sync_clr) begin
          m_run[i] = 0; m_lvl0[i] = 0; m_step[i] = 0;
        end
      end
    end
  end

  // Compare on the edge opposite the one the design updates on.
  always @(posedge CLOCK) begin
    logic [7:0] e_clk;
    logic [7:0] e_tick;
    if (chk_on) begin
      e_clk  = '0;
      e_tick = '0;
      for (int i = 0; i < NCH; i++) begin
        e_clk[i]  = m_clk(i);
        e_tick[i] = m_tick(i);
      end
      check("div_clk", {5'b0, div_clk}, e_clk);
      check("tick",    {5'b0, tick},    e_tick);
      check("cfg_err", {7'b0, cfg_err}, {7'b0, m_err});
    end
  end

  // Advance n falling edges; ends 1 time unit after a rising edge.
  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge CLOCK);
      #1;
    end
  endtask

  initial begin
    RESET_N = 1'b0; en = '0; sync_clr = 1'b0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_half = '0;
    @(posedge CLOCK); #1;
    tick_n(2);
    chk_on = 1;
    check("rst_div", {5'b0, div_clk}, 8'h00);
    check("rst_err", {7'b0, cfg_err}, 8'h00);

    // 1: release with all channels enabled; first rise after 5 edges.
    RESET_N = 1'b1; en = 3'b111;
    tick_n(4);  check("t1_pre_rise", {5'b0, div_clk}, 8'h00);
    tick_n(1);  check("t1_rise",     {5'b0, div_clk}, 8'h07);
                check("t1_tick",     {5'b0, tick},    8'h07);
    tick_n(1);  check("t1_tick_off", {5'b0, tick},    8'h00);
    tick_n(4);  check("t1_fall",     {5'b0, div_clk}, 8'h00);
    tick_n(5);  check("t1_rise2",    {5'b0, div_clk}, 8'h07);

    // 2: channel 1 to HALF=1; level kept on the write edge.
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_half = 32'd1;
    tick_n(1);  check("t2_kept", {5'b0, div_clk}, 8'h07);
    cfg_we = 1'b0;
    tick_n(1);  check("t2_fast_fall", {5'b0, div_clk}, 8'h05);
    tick_n(1);  check("t2_fast_rise", {5'b0, div_clk}, 8'h07);
                check("t2_fast_tick", {5'b0, tick},    8'h02);

    // 3: rejected writes.
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_half = 32'd0;
    tick_n(1);  check("t3_err_zero", {7'b0, cfg_err}, 8'h01);
    cfg_we = 1'b0;
    tick_n(1);  check("t3_err_clr",  {7'b0, cfg_err}, 8'h00);
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_half = 32'd7;
    tick_n(1);  check("t3_err_ch",   {7'b0, cfg_err}, 8'h01);
    cfg_we = 1'b0;

    // 4: freeze channel 2 at cnt=1 for 7 edges; resumes 4 edges later.
    en = 3'b011;
    tick_n(7);  check("t4_frozen", {7'b0, div_clk[2]}, 8'h00);
    en = 3'b111;
    tick_n(3);  check("t4_pre_rise", {7'b0, div_clk[2]}, 8'h00);
    tick_n(1);  check("t4_rise",     {7'b0, div_clk[2]}, 8'h01);
                check("t4_tick",     {7'b0, tick[2]},    8'h01);

    // 5: sync clear together with a write of HALF=3 to channel 0.
    sync_clr = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd0; cfg_half = 32'd3;
    tick_n(1);  check("t5_clr_div",  {5'b0, div_clk}, 8'h00);
                check("t5_clr_tick", {5'b0, tick},    8'h00);
    sync_clr = 1'b0; cfg_we = 1'b0;
    tick_n(3);  check("t5_e3_div",  {5'b0, div_clk}, 8'h03);
                check("t5_e3_tick", {5'b0, tick},    8'h03);
    tick_n(2);  check("t5_e5_div",  {5'b0, div_clk}, 8'h07);
                check("t5_e5_tick", {5'b0, tick},    8'h06);
    tick_n(1);  check("t6_pre_rst", {5'b0, div_clk}, 8'h04);

    // 6: async reset between edges; HALF returns to 5 everywhere.
    #3 RESET_N = 1'b0;
    #1 check("t6_async_div", {5'b0, div_clk}, 8'h00);
    @(posedge CLOCK); #1;
    RESET_N = 1'b1;
    tick_n(3);  check("t6_ch0_def", {5'b0, div_clk}, 8'h00);
    tick_n(2);  check("t6_rise",    {5'b0, div_clk}, 8'h07);
    tick_n(12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
